// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer between the multicycle control unit and a single-port word RAM.
// Edge-detects memRead/memWrite levels, absorbs fixed RAM read latency and pulses done on completion.
module mem_access_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-3:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LAT);

  state_t     state;
  state_t     next_state;
  logic [2:0] cnt;
  logic [2:0] next_cnt;
  logic       rd_q;
  logic       wr_q;
  logic       rd_start;
  logic       wr_start;
  logic       misaligned;
  logic       reject;
  logic       accept_rd;
  logic       accept_wr;
  logic       capture;

  assign rd_start   = memRead & ~rd_q;
  assign wr_start   = memWrite & ~wr_q;
  assign misaligned = (addr[1:0] != 2'b00);

  // Next-state and access-decision logic.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    reject     = 1'b0;
    accept_rd  = 1'b0;
    accept_wr  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if ((rd_start && wr_start) || ((rd_start || wr_start) && misaligned)) begin
          reject = 1'b1;
        end else if (rd_start) begin
          accept_rd  = 1'b1;
          next_cnt   = LAT;
          next_state = READ_WAIT;
        end else if (wr_start) begin
          accept_wr  = 1'b1;
          next_state = WRITE;
        end else begin
          next_state = IDLE;
        end
      end
      READ_WAIT: begin
        // cnt counts down to 1; data is sampled on the last wait cycle
        if (cnt <= 3'd1) begin
          capture    = 1'b1;
          next_cnt   = 3'd0;
          next_state = DONE;
        end else begin
          next_cnt = cnt - 3'd1;
        end
      end
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, edge registers, datapath capture and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      ram_wr    <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      rd_q  <= memRead;
      wr_q  <= memWrite;
      if (accept_rd || accept_wr) begin
        ram_addr <= addr[ADDR_W-1:2];
      end
      if (accept_wr) begin
        ram_wdata <= wdata;
      end
      if (capture) begin
        rdata <= ram_rdata;
      end
      // Outputs decoded from next_state so they line up with the state register
      done   <= (next_state == DONE);
      busy   <= (next_state == READ_WAIT) || (next_state == WRITE);
      ram_wr <= (next_state == WRITE);
      err    <= reject;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl, with extra instances at READ_LAT = 1 and 4.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic        rd1 = 1'b0;
  logic        rd4 = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic [29:0] ram_addr;
  logic        done, busy, err, ram_wr;
  logic [31:0] rdata1, ram_wdata1, ram_rdata1;
  logic [29:0] ram_addr1;
  logic        done1, busy1, err1, ram_wr1;
  logic [31:0] rdata4, ram_wdata4, ram_rdata4;
  logic [29:0] ram_addr4;
  logic        done4, busy4, err4, ram_wr4;

  logic [31:0] mem [0:15];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int d0, w0, lat;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .READ_LAT(2)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .err(err), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) u1 (
    .clk(clk), .reset(reset), .memRead(rd1), .memWrite(1'b0), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .done(done1), .busy(busy1), .err(err1), .ram_addr(ram_addr1), .ram_wr(ram_wr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1));

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .READ_LAT(4)) u4 (
    .clk(clk), .reset(reset), .memRead(rd4), .memWrite(1'b0), .addr(addr), .wdata(wdata),
    .rdata(rdata4), .done(done4), .busy(busy4), .err(err4), .ram_addr(ram_addr4), .ram_wr(ram_wr4),
    .ram_wdata(ram_wdata4), .ram_rdata(ram_rdata4));

  assign ram_rdata  = mem[ram_addr[3:0]];
  assign ram_rdata1 = mem[ram_addr1[3:0]];
  assign ram_rdata4 = mem[ram_addr4[3:0]];

  // RAM model: preload during reset, otherwise written by the main instance.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hA5A5_0000;
      mem[1] <= 32'h1111_2222;
      mem[4] <= 32'hDEAD_BEEF;
    end else if (ram_wr) begin
      mem[ram_addr[3:0]] <= ram_wdata;
    end
  end

  // Count done pulses and write strobes of the main instance mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ram_wr) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int sel, output int n);
    logic d;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      d = (sel == 0) ? done : ((sel == 1) ? done1 : done4);
      if (d) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    load  = 1'b0;
    check("rst_rdata", rdata, 32'h0);
    check("rst_flags", {28'h0, done, busy, err, ram_wr}, 32'h0);
    check("rst_ram_addr", {2'b00, ram_addr}, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);

    // Read of 0x10 with memRead held two cycles
    d0 = done_cnt; w0 = wr_cnt;
    addr = 32'h0000_0010; memRead = 1'b1;
    tick();
    check("rd_busy", {31'h0, busy}, 32'h1);
    check("rd_ram_addr", {2'b00, ram_addr}, 32'h4);
    tick();
    memRead = 1'b0;
    wait_done(0, lat);
    check("rd_latency", lat + 2, 32'd3);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);
    tick(); tick(); tick();
    check("rd_one_done", done_cnt - d0, 32'd1);

    // Write 0x1234_5678 to 0x20
    d0 = done_cnt; w0 = wr_cnt;
    addr = 32'h0000_0020; wdata = 32'h1234_5678; memWrite = 1'b1;
    tick();
    check("wr_ram_wr", {31'h0, ram_wr}, 32'h1);
    check("wr_ram_addr", {2'b00, ram_addr}, 32'h8);
    check("wr_ram_wdata", ram_wdata, 32'h1234_5678);
    memWrite = 1'b0;
    tick();
    check("wr_done", {31'h0, done}, 32'h1);
    check("wr_ram_wr_drop", {31'h0, ram_wr}, 32'h0);
    check("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
    tick(); tick();
    check("wr_one_strobe", wr_cnt - w0, 32'd1);
    check("wr_one_done", done_cnt - d0, 32'd1);

    // Misaligned read and simultaneous read/write are rejected
    d0 = done_cnt; w0 = wr_cnt;
    addr = 32'h0000_0013; memRead = 1'b1;
    tick();
    check("mis_err", {31'h0, err}, 32'h1);
    check("mis_busy", {31'h0, busy}, 32'h0);
    memRead = 1'b0;
    tick();
    check("mis_err_pulse", {31'h0, err}, 32'h0);
    addr = 32'h0000_0010; memRead = 1'b1; memWrite = 1'b1;
    tick();
    check("both_err", {31'h0, err}, 32'h1);
    memRead = 1'b0; memWrite = 1'b0;
    tick(); tick(); tick();
    check("rej_no_done", done_cnt - d0, 32'd0);
    check("rej_no_write", wr_cnt - w0, 32'd0);

    // Write edge during READ_WAIT is ignored
    d0 = done_cnt; w0 = wr_cnt;
    addr = 32'h0; memRead = 1'b1;
    tick();
    addr = 32'h4; memWrite = 1'b1; wdata = 32'hFFFF_FFFF;
    tick();
    check("busy_no_err", {31'h0, err}, 32'h0);
    memRead = 1'b0; memWrite = 1'b0;
    wait_done(0, lat);
    check("busy_latency", lat + 2, 32'd3);
    check("busy_rdata", rdata, 32'hA5A5_0000);
    tick(); tick(); tick();
    check("busy_one_done", done_cnt - d0, 32'd1);
    check("busy_no_write", wr_cnt - w0, 32'd0);

    // Reset in READ_WAIT aborts the read
    addr = 32'h4; memRead = 1'b1;
    tick();
    check("abort_busy_pre", {31'h0, busy}, 32'h1);
    reset = 1'b1; memRead = 1'b0;
    tick();
    d0 = done_cnt;
    check("abort_rdata", rdata, 32'h0);
    check("abort_flags", {28'h0, done, busy, err, ram_wr}, 32'h0);
    reset = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("abort_no_done", done_cnt - d0, 32'd0);
    addr = 32'h0; memRead = 1'b1;
    tick();
    memRead = 1'b0;
    wait_done(0, lat);
    check("fresh_latency", lat + 1, 32'd3);
    check("fresh_rdata", rdata, 32'hA5A5_0000);

    // Back-to-back: read 0x4, write 0x4 right after DONE, read back
    tick();
    addr = 32'h4; memRead = 1'b1;
    tick();
    memRead = 1'b0;
    wait_done(0, lat);
    check("b2b_rd_rdata", rdata, 32'h1111_2222);
    tick();
    wdata = 32'hCAFE_F00D; memWrite = 1'b1;
    tick();
    check("b2b_wr_accept", {31'h0, ram_wr}, 32'h1);
    memWrite = 1'b0;
    wait_done(0, lat);
    check("b2b_wr_latency", lat + 1, 32'd2);
    tick();
    memRead = 1'b1;
    tick();
    memRead = 1'b0;
    wait_done(0, lat);
    check("b2b_readback", rdata, 32'hCAFE_F00D);
    tick();

    // Latency at READ_LAT = 1 and 4
    addr = 32'h10; rd1 = 1'b1;
    wait_done(1, lat);
    check("lat1_latency", lat, 32'd2);
    check("lat1_rdata", rdata1, 32'hDEAD_BEEF);
    rd1 = 1'b0;
    tick();
    rd4 = 1'b1;
    tick();
    check("lat4_busy", {31'h0, busy4}, 32'h1);
    wait_done(2, lat);
    check("lat4_latency", lat + 1, 32'd5);
    check("lat4_rdata", rdata4, 32'hDEAD_BEEF);
    rd4 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-access sequencer between the multicycle control unit and the single-port word RAM.
- Turns the control unit's memRead/memWrite request levels into correctly timed RAM cycles.
- Absorbs the fixed RAM read latency and captures read data into a holding register for the instruction/data path.
- Signals completion with a one-cycle done pulse, so the control FSM can advance to PC write or decode.

Parameters:
- ADDR_W, 32, width of the byte address from the datapath
- DATA_W, 32, data word width
- READ_LAT, 2, cycles from ram_addr being presented to ram_rdata being valid; legal range 1..7

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- memRead  in  1  read request level from the control unit
- memWrite  in  1  write request level from the control unit
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  registered read data, held until the next completed read
- done  out  1  one-cycle pulse when an access completes
- busy  out  1  high while an access is in progress
- err  out  1  one-cycle pulse on a rejected request
- ram_addr  out  ADDR_W-2  registered word address (addr[ADDR_W-1:2])
- ram_wr  out  1  RAM write enable
- ram_wdata  out  DATA_W  registered write data
- ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset is sampled on the clk rising edge. Reset values:
  - state = IDLE
  - rdata, ram_addr, ram_wdata = 0
  - done, busy, err, ram_wr = 0
  - request-edge registers and latency counter = 0
- Reset mid-access aborts the access: no done pulse, ram_wr drops on that edge, rdata returns to 0.
- Requests are edge-triggered. The block keeps rd_q/wr_q, the previous-cycle values of memRead/memWrite.
  - rd_start = memRead & ~rd_q
  - wr_start = memWrite & ~wr_q
  - A request level held for several cycles (e.g. across MemoryRead and WaitMemoryRead) produces exactly one access.
- States: IDLE, READ_WAIT, WRITE, DONE.
- IDLE, busy = 0:
  - rd_start & wr_start, or any start with addr[1:0] != 0: stay in IDLE, pulse err next cycle, no RAM access.
  - rd_start only: latch ram_addr, load cnt = READ_LAT, go to READ_WAIT.
  - wr_start only: latch ram_addr and ram_wdata, go to WRITE.
- READ_WAIT, busy = 1: decrement cnt each cycle. When cnt reaches 1, capture ram_rdata into rdata and go to DONE.
- WRITE, busy = 1: ram_wr = 1 for exactly this one cycle, then go to DONE.
- DONE: done = 1 and busy = 0 for one cycle, then return to IDLE.
- Latency:
  - Read: done asserts READ_LAT+1 cycles after the cycle in which rd_start is seen, with rdata valid in the same cycle. Default READ_LAT = 2 gives 3 cycles.
  - Write: done asserts 2 cycles after wr_start.
- Starts arriving while state != IDLE are ignored and not queued; err is not raised for them. The edge registers keep tracking, so a level still held when returning to IDLE does not retrigger.
- A start is accepted in the cycle immediately after DONE, giving back-to-back accesses.
- ram_wr is never high outside the WRITE state. ram_addr and ram_wdata hold their last values when idle.
- rdata changes only on a completed read (or on reset). Writes never alter rdata.
- Address arithmetic is pure truncation: word address = addr >> 2, with no wrap handling. Address 0xFFFFFFFC maps to word 0x3FFFFFFF.

Test Plan:
- Reset then read: hold memRead high 2 cycles, addr = 0x0000_0010, RAM word 4 = 0xDEAD_BEEF → ram_addr = 4; done pulses once, 3 cycles after the request edge; rdata = 0xDEAD_BEEF; no second access.
- Write: memWrite pulse, addr = 0x20, wdata = 0x1234_5678 → ram_wr high for exactly 1 cycle with ram_addr = 8, ram_wdata = 0x1234_5678; done 2 cycles after the edge; rdata unchanged.
- Misaligned and simultaneous requests: memRead edge with addr = 0x13 → err pulse, ram_wr stays 0, busy stays 0, no done. memRead and memWrite rising together → err pulse, no access.
- Request while busy: memWrite edge during READ_WAIT → ignored; the read completes normally; exactly one done pulse; ram_wr stays 0 throughout.
- Reset mid-read: assert reset in READ_WAIT → next cycle state IDLE, rdata = 0, done = 0, and no later done pulse. Then a fresh read of addr 0x0 returns the RAM word 0 value.
- Back-to-back: read addr 0x4 followed by a write to 0x4 issued in the cycle after done → both complete, and a third read returns the written value. Also run with READ_LAT = 1 and READ_LAT = 4: read done at 2 and 5 cycles after the request edge.
